// File: rtl/shifter_pkg.sv
// shifter_pkg: op encodings and pipeline latency shared by pipe_shifter and its bench
package shifter_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  localparam int SHIFTER_LATENCY = 2;
endpackage

// File: rtl/shift_level.sv
// shift_level: one barrel-shifter mux level, shifts by K when enabled with mode-dependent fill
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic [1:0]       i_op,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] w_sh;
  always_comb w_sh = i_op == OP_SLL ? i_data << K :
                     i_op == OP_SRL ? i_data >> K :
                     i_op == OP_SRA ? {{K{i_sign}}, i_data[WIDTH-1:K]} :
                                      {i_data[K-1:0], i_data[WIDTH-1:K]};
  assign o_data = i_en ? w_sh : i_data;
endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage valid/ready pipelined barrel shifter (SLL/SRL/SRA/ROR).
// Define PIPE_SHIFTER_ZERO_FLAG_EN to add the registered out_zero result flag.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LO = SHAMT_W / 2;
  logic [WIDTH-1:0] w_a [LO:SHAMT_W];
  logic [WIDTH-1:0] w_b [0:LO];
  logic             w_s1_adv, w_s2_adv;
  logic             r_s1_valid, r_s1_sign, r_s2_valid;
  logic [WIDTH-1:0] r_s1_data, r_s2_data;
  logic [1:0]       r_s1_op;
  logic [LO-1:0]    r_s1_shamt;
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  logic             r_zero;
  assign out_zero = r_zero;
`endif
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  // S1 resolves the high shamt bits; SRA fill always uses the operand's original sign
  assign w_a[SHAMT_W] = in_data;
  for (genvar i = LO; i < SHAMT_W; i++) begin : g_s1
    shift_level #(.WIDTH(WIDTH), .K(1 << i)) u_lvl (
      .i_data (w_a[i+1]),
      .i_en   (in_shamt[i]),
      .i_op   (in_op),
      .i_sign (in_data[WIDTH-1]),
      .o_data (w_a[i])
    );
  end
  assign w_b[LO] = r_s1_data;
  for (genvar i = 0; i < LO; i++) begin : g_s2
    shift_level #(.WIDTH(WIDTH), .K(1 << i)) u_lvl (
      .i_data (w_b[i+1]),
      .i_en   (r_s1_shamt[i]),
      .i_op   (r_s1_op),
      .i_sign (r_s1_sign),
      .o_data (w_b[i])
    );
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_op    <= '0;
      r_s1_shamt <= '0;
      r_s1_sign  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
      r_zero     <= 1'b0;
`endif
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s1_adv && in_valid) begin
        r_s1_data  <= w_a[LO];
        r_s1_op    <= in_op;
        r_s1_shamt <= in_shamt[LO-1:0];
        r_s1_sign  <= in_data[WIDTH-1];
      end
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_s2_data <= w_b[0];
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
        r_zero    <= w_b[0] == '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: randomized self-checking bench for pipe_shifter (32- and 8-bit instances)
module tb_pipe_shifter;
  import shifter_pkg::*;
  typedef struct {logic [31:0] d; int c;} ent_t;
  logic        clock = 0, resetn = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready;
  logic        rdy_drv = 1, rnd_bp = 0, rnd_bit = 1, lat_chk = 1, seen = 0;
  logic [31:0] in_data = 0, out_data, exp_in = 0;
  logic [4:0]  in_shamt = 0;
  logic [1:0]  in_op = 0;
  logic        in_valid8 = 0, in_ready8, out_valid8;
  logic [7:0]  in_data8 = 0, out_data8;
  logic [2:0]  in_shamt8 = 0;
  logic [1:0]  in_op8 = 0;
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  logic        out_zero, out_zero8;
`endif
  int          errs = 0, checks = 0, cyc = 0;
  ent_t        q[$];
  assign out_ready = rnd_bp ? rnd_bit : rdy_drv;
  pipe_shifter #(.WIDTH(32)) u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );
  pipe_shifter #(.WIDTH(8)) u_dut8 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_shamt(in_shamt8), .in_op(in_op8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_data(out_data8)
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    , .out_zero(out_zero8)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always begin
    @(posedge clock);
    #1;
    rnd_bit = 1'($urandom_range(1));
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input logic [1:0] op, input int w);
    logic [63:0] m, x;
    m = (64'd1 << w) - 64'd1;
    x = d & m;
    if (op == OP_SLL) return (x << s) & m;
    if (op == OP_SRL) return x >> s;
    if (op == OP_SRA) return ($signed(x[w-1] ? x | ~m : x) >>> s) & m;
    return ((x >> s) | (x << (w - s))) & m;
  endfunction
  // Expected results are queued at accept time and retired in order at each output transfer
  always @(negedge clock) begin
    if (!resetn) begin
      q.delete();
      seen = 0;
    end else begin
      if (q.size() == 0) chk("spurious", 64'(out_valid), 0);
      else if (out_valid) begin
        chk("data", 64'(out_data), 64'(q[0].d));
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
        chk("zero", 64'(out_zero), 64'(q[0].d == 0));
`endif
        if (!seen && lat_chk) chk("latency", 64'(cyc - q[0].c), 64'(SHIFTER_LATENCY));
        seen = 1;
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
      if (in_valid && in_ready) q.push_back('{exp_in, cyc});
    end
  end
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o, input logic [31:0] e);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_shamt = s;
    in_op = o;
    exp_in = e;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 1);
    @(posedge clock);
    #1;
  endtask
  task automatic sendm(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    logic [63:0] e;
    e = ref_shift(64'(d), int'(s), o, 32);
    send(d, s, o, e[31:0]);
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("drain", 64'(q.size()), 0);
    @(posedge clock);
    #1;
  endtask
  task automatic run8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] o, input logic [7:0] e);
    int n = 0;
    in_valid8 = 1;
    in_data8 = d;
    in_shamt8 = s;
    in_op8 = o;
    @(negedge clock);
    chk("w8_ready", 64'(in_ready8), 1);
    @(posedge clock);
    #1;
    in_valid8 = 0;
    while (!out_valid8 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("w8_latency", 64'(n), 64'(SHIFTER_LATENCY));
    chk("w8_data", 64'(out_data8), 64'(e));
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    chk("w8_zero", 64'(out_zero8), 64'(e == 0));
`endif
    @(posedge clock);
    #1;
  endtask
  initial begin
    logic [63:0] e;
    logic [7:0]  d8;
    logic [2:0]  s8;
    logic [1:0]  o8;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_valid8", 64'(out_valid8), 0);
    @(posedge clock);
    #2;
    resetn = 1;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clock);
    #1;
    send(32'h80000000, 5'd4, OP_SRA, 32'hF8000000);
    send(32'h80000000, 5'd4, OP_SRL, 32'h08000000);
    send(32'h00000001, 5'd31, OP_SLL, 32'h80000000);
    send(32'h00000001, 5'd1, OP_ROR, 32'h80000000);
    send(32'h12345678, 5'd16, OP_ROR, 32'h56781234);
    for (int i = 0; i < 4; i++) send(32'hDEADBEEF, 5'd0, 2'(i), 32'hDEADBEEF);
    drain();
    // Backpressure: two ops fill the pipe, the third must wait
    lat_chk = 0;
    rdy_drv = 0;
    send(32'h1, 5'd1, OP_SLL, 32'h2);
    send(32'h1, 5'd2, OP_SLL, 32'h4);
    in_data = 32'h1;
    in_shamt = 5'd3;
    exp_in = 32'h8;
    repeat (3) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_out_valid", 64'(out_valid), 1);
    end
    @(posedge clock);
    #1;
    rdy_drv = 1;
    send(32'h1, 5'd3, OP_SLL, 32'h8);
    drain();
    lat_chk = 1;
    repeat (20) sendm($urandom, 5'($urandom_range(31)), 2'($urandom_range(3)));
    drain();
    lat_chk = 0;
    rnd_bp = 1;
    repeat (40) sendm($urandom, 5'($urandom_range(31)), 2'($urandom_range(3)));
    rnd_bp = 0;
    drain();
    lat_chk = 1;
    // Asynchronous reset with two ops in flight
    send(32'hCAFEF00D, 5'd3, OP_SRL, 32'h195FDE01);
    send(32'hFFFF0000, 5'd8, OP_SRA, 32'hFFFFFF00);
    in_valid = 0;
    #1;
    resetn = 0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 0);
    chk("rst_mid_out_data", 64'(out_data), 0);
    @(negedge clock);
    @(posedge clock);
    #3;
    resetn = 1;
    repeat (4) @(negedge clock);
    chk("rst_rel_in_ready", 64'(in_ready), 1);
    chk("rst_rel_out_valid", 64'(out_valid), 0);
    @(posedge clock);
    #1;
    run8(8'h90, 3'd7, OP_SRA, 8'hFF);
    run8(8'h81, 3'd4, OP_ROR, 8'h18);
    run8(8'h01, 3'd1, OP_SRL, 8'h00);
    repeat (8) begin
      d8 = 8'($urandom);
      s8 = 3'($urandom_range(7));
      o8 = 2'($urandom_range(3));
      e = ref_shift(64'(d8), int'(s8), o8, 8);
      run8(d8, s8, o8, e[7:0]);
    end
    sendm(32'h0F0F0F0F, 5'd4, OP_SLL);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
